// File: rtl/video_pkg.sv
// -----------------------------------------------------------------------------
// video_pkg
// Shared constants and types for the 40x25 text video fetch path.
//   - Default raster timing (bus cycles per line, lines per frame, sync spans)
//   - Glyph height and the derived rom_addr line-field width
//   - ram_addr / rom_addr widths and the rom_addr bit-field layout
//   - Packed types for the character ROM address and the per-cycle raster flags
// -----------------------------------------------------------------------------
package video_pkg;

    // Default raster timing, in bus cycles (horizontal) and scan lines (vertical)
    localparam int DEF_H_ACTIVE     = 40;
    localparam int DEF_H_TOTAL      = 64;
    localparam int DEF_H_SYNC_START = 48;
    localparam int DEF_H_SYNC_LEN   = 4;
    localparam int DEF_V_ACTIVE     = 200;
    localparam int DEF_V_TOTAL      = 260;
    localparam int DEF_V_SYNC_START = 224;
    localparam int DEF_V_SYNC_LEN   = 4;

    // Scan lines per character row
    localparam int CHAR_ROWS = 8;
    localparam int LINE_BITS = $clog2(CHAR_ROWS);

    // Counter widths are sized from the default totals
    localparam int H_COUNT_W = $clog2(DEF_H_TOTAL);
    localparam int V_LINE_W  = $clog2(DEF_V_TOTAL);

    localparam int RAM_ADDR_W = 10;
    localparam int ROM_ADDR_W = 11;

    // rom_addr layout: {graphic, char_code[6:0], v_line[2:0]}
    localparam int ROM_LINE_LSB = 0;
    localparam int ROM_CODE_LSB = ROM_LINE_LSB + LINE_BITS;
    localparam int ROM_GFX_BIT  = ROM_CODE_LSB + 7;

    typedef struct packed {
        logic                 graphic;
        logic [6:0]           code;
        logic [LINE_BITS-1:0] line;
    } rom_addr_t;

    // Raster state of the character being fetched, pipelined with its pixels
    typedef struct packed {
        logic de;
        logic h_sync;
        logic v_sync;
    } raster_flags_t;

endpackage

// File: rtl/video_raster.sv
// -----------------------------------------------------------------------------
// video_raster
// Raster counters for the text display. Advances one character column per
// bus cycle and produces the video RAM address plus the display-enable and
// sync flags for the column currently being fetched.
//   clk16       in  system clock
//   reset_n     in  asynchronous active-low reset
//   advance     in  one-clock pulse per bus cycle (the RAM edge)
//   ram_addr    out row_base + h_count, valid until the next advance
//   v_line      out current scan line (its low bits select the glyph row)
//   next_flags  out de / h_sync / v_sync for the current (h_count, v_line)
// -----------------------------------------------------------------------------
module video_raster
    import video_pkg::*;
#(
    parameter int H_ACTIVE     = DEF_H_ACTIVE,
    parameter int H_TOTAL      = DEF_H_TOTAL,
    parameter int H_SYNC_START = DEF_H_SYNC_START,
    parameter int H_SYNC_LEN   = DEF_H_SYNC_LEN,
    parameter int V_ACTIVE     = DEF_V_ACTIVE,
    parameter int V_TOTAL      = DEF_V_TOTAL,
    parameter int V_SYNC_START = DEF_V_SYNC_START,
    parameter int V_SYNC_LEN   = DEF_V_SYNC_LEN
) (
    input  logic                  clk16,
    input  logic                  reset_n,
    input  logic                  advance,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic [V_LINE_W-1:0]   v_line,
    output raster_flags_t         next_flags
);

    localparam logic [H_COUNT_W-1:0]  H_LAST    = H_COUNT_W'(H_TOTAL - 1);
    localparam logic [H_COUNT_W-1:0]  H_ACT     = H_COUNT_W'(H_ACTIVE);
    localparam logic [H_COUNT_W-1:0]  HS_FIRST  = H_COUNT_W'(H_SYNC_START);
    localparam logic [H_COUNT_W-1:0]  HS_END    = H_COUNT_W'(H_SYNC_START + H_SYNC_LEN);
    localparam logic [V_LINE_W-1:0]   V_LAST    = V_LINE_W'(V_TOTAL - 1);
    localparam logic [V_LINE_W-1:0]   V_ACT     = V_LINE_W'(V_ACTIVE);
    localparam logic [V_LINE_W-1:0]   VS_FIRST  = V_LINE_W'(V_SYNC_START);
    localparam logic [V_LINE_W-1:0]   VS_END    = V_LINE_W'(V_SYNC_START + V_SYNC_LEN);
    localparam logic [LINE_BITS-1:0]  ROW_LAST  = LINE_BITS'(CHAR_ROWS - 1);
    localparam logic [RAM_ADDR_W-1:0] ROW_STEP  = RAM_ADDR_W'(H_ACTIVE);

    logic [H_COUNT_W-1:0]  h_count;
    logic [RAM_ADDR_W-1:0] row_base;

    always_ff @(posedge clk16 or negedge reset_n) begin
        if (!reset_n) begin
            h_count  <= '0;
            v_line   <= '0;
            row_base <= '0;
        end else if (advance) begin
            if (h_count == H_LAST) begin
                h_count <= '0;
                if (v_line == V_LAST) begin
                    v_line   <= '0;
                    row_base <= '0;
                end else begin
                    v_line <= v_line + 1'b1;
                    // Step to the next text row after its last glyph line;
                    // below the active area row_base is left parked.
                    if (v_line[LINE_BITS-1:0] == ROW_LAST && v_line < V_ACT)
                        row_base <= row_base + ROW_STEP;
                end
            end else begin
                h_count <= h_count + 1'b1;
            end
        end
    end

    // 10-bit sum wraps on its own; row_base never exceeds 1000 at defaults
    assign ram_addr = row_base + RAM_ADDR_W'(h_count);

    assign next_flags.de     = (h_count < H_ACT) && (v_line < V_ACT);
    assign next_flags.h_sync = (h_count >= HS_FIRST) && (h_count < HS_END);
    assign next_flags.v_sync = (v_line >= VS_FIRST) && (v_line < VS_END);

endmodule

// File: rtl/video_fetch.sv
// -----------------------------------------------------------------------------
// video_fetch
// Character fetch and pixel serializer for a 40x25 text display. Each 16-clock
// bus cycle fetches a character code from video RAM and a glyph byte from the
// character ROM, then shifts the previous cycle's glyph out one pixel per two
// clk16. Syncs ride the same one-cycle pipeline as display enable.
//   clk16            in  16 MHz system clock
//   reset_n          in  asynchronous active-low reset
//   clk8             in  clk16/2 phase; shifting happens while it is low
//   video_ram_strobe in  RAM read strobe, once per bus cycle
//   video_rom_strobe in  char ROM read strobe, two clocks after the RAM strobe
//   data_in          in  shared memory data bus
//   graphic          in  character set select (ROM A10)
//   ram_addr         out video RAM address (row_base + h_count)
//   rom_addr         out {graphic, char_code[6:0], v_line[2:0]}
//   pixel            out serial video, 1 = lit
//   h_sync, v_sync   out active-high syncs
// -----------------------------------------------------------------------------
module video_fetch
    import video_pkg::*;
#(
    parameter int H_ACTIVE     = DEF_H_ACTIVE,
    parameter int H_TOTAL      = DEF_H_TOTAL,
    parameter int H_SYNC_START = DEF_H_SYNC_START,
    parameter int H_SYNC_LEN   = DEF_H_SYNC_LEN,
    parameter int V_ACTIVE     = DEF_V_ACTIVE,
    parameter int V_TOTAL      = DEF_V_TOTAL,
    parameter int V_SYNC_START = DEF_V_SYNC_START,
    parameter int V_SYNC_LEN   = DEF_V_SYNC_LEN
) (
    input  logic                  clk16,
    input  logic                  reset_n,
    input  logic                  clk8,
    input  logic                  video_ram_strobe,
    input  logic                  video_rom_strobe,
    input  logic [7:0]            data_in,
    input  logic                  graphic,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    output logic                  pixel,
    output logic                  h_sync,
    output logic                  v_sync
);

    logic [V_LINE_W-1:0] v_line;
    raster_flags_t       next_flags;
    raster_flags_t       flags_q;
    rom_addr_t           rom_fields;
    logic [7:0]          char_code;
    logic [7:0]          glyph;
    logic [7:0]          shift_reg;

    video_raster #(
        .H_ACTIVE     (H_ACTIVE),
        .H_TOTAL      (H_TOTAL),
        .H_SYNC_START (H_SYNC_START),
        .H_SYNC_LEN   (H_SYNC_LEN),
        .V_ACTIVE     (V_ACTIVE),
        .V_TOTAL      (V_TOTAL),
        .V_SYNC_START (V_SYNC_START),
        .V_SYNC_LEN   (V_SYNC_LEN)
    ) u_raster (
        .clk16      (clk16),
        .reset_n    (reset_n),
        .advance    (video_ram_strobe),
        .ram_addr   (ram_addr),
        .v_line     (v_line),
        .next_flags (next_flags)
    );

    // NOTE: all storage here is plain flops on the async reset, so pixel and
    // syncs drop the instant reset_n falls rather than at the next edge.
    always_ff @(posedge clk16 or negedge reset_n) begin
        if (!reset_n) begin
            char_code <= '0;
            glyph     <= '0;
            shift_reg <= '0;
            flags_q   <= '0;
        end else if (video_ram_strobe) begin
            // NOTE: non-blocking assignment means char_code and flags_q on the
            // right-hand side still hold last cycle's values, which is exactly
            // the character whose glyph is loaded now.
            char_code <= data_in;
            shift_reg <= flags_q.de ? (glyph ^ {8{char_code[7]}}) : 8'h00;
            flags_q   <= next_flags;
        end else begin
            // A ROM strobe coinciding with the RAM strobe is dropped above
            if (video_rom_strobe)
                glyph <= data_in;
            if (!clk8)
                shift_reg <= {shift_reg[6:0], 1'b0};
        end
    end

    // Valid as soon as char_code is latched, well ahead of the ROM strobe
    assign rom_fields = '{graphic: graphic,
                          code:    char_code[6:0],
                          line:    v_line[LINE_BITS-1:0]};
    assign rom_addr   = rom_fields;

    // Blanked characters load 0x00, so the MSB is already forced dark
    assign pixel  = shift_reg[7];
    assign h_sync = flags_q.h_sync;
    assign v_sync = flags_q.v_sync;

endmodule

// File: tb/tb_video_fetch.sv
// -----------------------------------------------------------------------------
// tb_video_fetch
// Bench for video_fetch. The bench owns a video RAM and character ROM image
// and answers the strobes from them at addresses it works out from the raster
// position. Expected pixels come from the glyph of the previous character.
// -----------------------------------------------------------------------------
module tb_video_fetch;

    logic        clk16 = 1'b0;
    logic        reset_n = 1'b0;
    logic        clk8 = 1'b0;
    logic        video_ram_strobe = 1'b0;
    logic        video_rom_strobe = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic        graphic = 1'b0;
    logic [9:0]  ram_addr;
    logic [10:0] rom_addr;
    logic        pixel;
    logic        h_sync;
    logic        v_sync;

    video_fetch dut (
        .clk16            (clk16),
        .reset_n          (reset_n),
        .clk8             (clk8),
        .video_ram_strobe (video_ram_strobe),
        .video_rom_strobe (video_rom_strobe),
        .data_in          (data_in),
        .graphic          (graphic),
        .ram_addr         (ram_addr),
        .rom_addr         (rom_addr),
        .pixel            (pixel),
        .h_sync           (h_sync),
        .v_sync           (v_sync)
    );

    always #5 clk16 = ~clk16;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Memory images served to the DUT
    logic [7:0] vram [1024];
    logic [7:0] crom [2048];

    // Model: raster position of the next fetch and the glyph pipeline
    int         mh = 0;
    int         mv = 0;
    logic [7:0] pend_bits = 8'h00;   // fetched this cycle, shown next cycle
    logic [7:0] show_bits = 8'h00;   // being shifted out this cycle
    bit         rand_gfx  = 1'b0;

    // Observations of the most recent bus cycle
    logic [7:0]  last_byte;
    logic [10:0] last_rom;
    logic [9:0]  last_ram;
    logic        last_hs;
    logic        last_vs;

    // One bus cycle of len clocks (RAM strobe at phase 0, ROM strobe at
    // phase 2). If rst_at >= 0, reset is pulsed at that phase and the cycle
    // is abandoned.
    task automatic bus_cycle(input int len, input int rst_at);
        int          rb;
        int          addr;
        int          vnext;
        logic        g;
        logic [7:0]  code;
        logic [7:0]  gl;
        logic [10:0] ra;
        logic        hs_e;
        logic        vs_e;
        logic [7:0]  obs;

        // Text row base stays parked at row 25 below the active area
        rb    = ((mv < 200 ? mv : 200) / 8) * 40;
        addr  = (rb + mh) % 1024;
        vnext = (mh == 63) ? ((mv == 259) ? 0 : mv + 1) : mv;
        g     = rand_gfx ? 1'($urandom_range(0, 1)) : 1'b0;
        code  = vram[addr];
        ra    = {g, code[6:0], 3'(vnext % 8)};
        gl    = crom[ra];
        hs_e  = (mh >= 48 && mh < 52);
        vs_e  = (mv >= 224 && mv < 228);

        check("ram_addr", ram_addr, addr);
        last_ram = ram_addr;
        graphic  = g;
        obs      = 8'h00;

        for (int p = 0; p < len; p++) begin
            clk8             = p[0];
            video_ram_strobe = (p == 0);
            video_rom_strobe = (p == 2);
            data_in          = (p == 0) ? code : (p == 2) ? gl : 8'($urandom);
            @(posedge clk16);
            #1;
            if (p == 0) begin
                show_bits = pend_bits;
                check("rom_addr", rom_addr, ra);
                last_rom = rom_addr;
                last_hs  = h_sync;
                last_vs  = v_sync;
            end
            check("pixel", pixel, show_bits[7 - p / 2]);
            check("h_sync", h_sync, hs_e);
            check("v_sync", v_sync, vs_e);
            if (p[0]) obs = {obs[6:0], pixel};

            if (p == rst_at) begin
                #1 reset_n = 1'b0;
                #1;
                check("rst_pixel", pixel, 1'b0);
                check("rst_h_sync", h_sync, 1'b0);
                check("rst_v_sync", v_sync, 1'b0);
                check("rst_ram_addr", ram_addr, 0);
                video_ram_strobe = 1'b0;
                video_rom_strobe = 1'b0;
                repeat (3) @(posedge clk16);
                #1 reset_n = 1'b1;
                mh        = 0;
                mv        = 0;
                pend_bits = 8'h00;
                show_bits = 8'h00;
                return;
            end
        end

        last_byte = obs;
        pend_bits = (mh < 40 && mv < 200) ? (gl ^ {8{code[7]}}) : 8'h00;
        mh++;
        if (mh == 64) begin
            mh = 0;
            mv = (mv == 259) ? 0 : mv + 1;
        end
    endtask

    int hs_cycles = 0;
    int vs_cycles = 0;

    initial begin
        for (int i = 0; i < 1024; i++) vram[i] = 8'($urandom);
        for (int i = 0; i < 2048; i++) crom[i] = 8'($urandom);
        vram[0]    = 8'h01;
        vram[1]    = 8'h81;
        crom[11'h008] = 8'hA5;
        for (int i = 40; i < 64; i++) vram[i] = 8'hFF;
        vram[1000] = 8'hFF;
        // Column 19 of line 5 is fully lit so the mid-line reset has pixels to kill
        vram[19]   = 8'h80;
        crom[{1'b0, 7'd0, 3'd5}] = 8'h00;
        crom[{1'b1, 7'd0, 3'd5}] = 8'h00;

        reset_n = 1'b0;
        repeat (3) @(posedge clk16);
        #1;
        check("reset_pixel", pixel, 1'b0);
        check("reset_h_sync", h_sync, 1'b0);
        check("reset_v_sync", v_sync, 1'b0);
        check("reset_ram_addr", ram_addr, 0);
        check("reset_rom_addr", rom_addr, 0);
        reset_n = 1'b1;

        // Full frame: first two lines at real bus timing, the rest compressed
        for (int i = 0; i < 64 * 260; i++) begin
            rand_gfx = (i >= 2);
            bus_cycle((i < 128) ? 16 : 4, -1);
            if (i < 64 && last_hs) hs_cycles++;
            if (last_vs) vs_cycles++;
            if (i == 0)  check("rom_addr_plain", last_rom, 11'h008);
            if (i == 1)  check("rom_addr_rev", last_rom, 11'h008);
            if (i == 1)  check("pattern_a5", last_byte, 8'hA5);
            if (i == 2)  check("pattern_5a", last_byte, 8'h5A);
            if (i == 41) check("blank_col40", last_byte, 8'h00);
            if (i == 8 * 64)       check("ram_addr_line8", last_ram, 40);
            if (i == 16 * 64)      check("ram_addr_line16", last_ram, 80);
            if (i == 199 * 64 + 39) check("ram_addr_last", last_ram, 999);
        end
        check("h_sync_cycles", hs_cycles, 4);
        check("v_sync_cycles", vs_cycles, 4 * 64);

        // Second frame begins back at the top-left character
        bus_cycle(4, -1);
        check("frame_wrap_addr", last_ram, 0);

        // Run to line 5, column 20 and reset mid-line while column 19 is lit
        while (!(mv == 5 && mh == 20)) bus_cycle(4, -1);
        bus_cycle(4, 3);

        // First display after reset is one bus cycle after the first fetch
        rand_gfx = 1'b0;
        bus_cycle(16, -1);
        check("post_reset_blank", last_byte, 8'h00);
        bus_cycle(16, -1);
        check("post_reset_first", last_byte, 8'hA5);

        // Reset while h_sync is asserted
        rand_gfx = 1'b1;
        while (mh != 50) bus_cycle(4, -1);
        bus_cycle(4, 1);
        repeat (4) bus_cycle(16, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
